// File: rtl/arbiter_puf_engine_pkg.sv
// Shared definitions for the arbiter PUF engine.
//   state_t      : controller states
//   tap_mask()   : Fibonacci LFSR feedback taps for a given challenge width
//   stages_legal : true when the challenge width has a tap set
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIRE,
    SAMPLE,
    RELAX,
    DONE
  } state_t;

  // Bit k set means state bit k feeds the XOR.
  function automatic logic [63:0] tap_mask(input int stages);
    case (stages)
      8:       tap_mask = 64'h0000_0000_0000_00B8;  // 7,5,4,3
      16:      tap_mask = 64'h0000_0000_0000_D008;  // 15,14,12,3
      32:      tap_mask = 64'h0000_0000_8020_0003;  // 31,21,1,0
      64:      tap_mask = 64'hD800_0000_0000_0000;  // 63,62,60,59
      default: tap_mask = 64'h0;
    endcase
  endfunction

  function automatic bit stages_legal(input int stages);
    return (stages == 8) || (stages == 16) || (stages == 32) || (stages == 64);
  endfunction

endpackage

// File: rtl/arbiter_puf_engine_if.sv
// Request/response handshake between the bus logic (master) and the
// PUF engine (slave).
//   istart/iseed        : request valid + seed challenge
//   oready              : engine idle
//   ovalid/iready       : response valid / consumer accepts
//   oresponse/ounstable : voted response and count of non-unanimous bits
interface arbiter_puf_engine_if #(
  parameter int STAGES    = 8,
  parameter int RESP_BITS = 16
);
  localparam int UNST_W = $clog2(RESP_BITS + 1);

  logic                  istart;
  logic [STAGES-1:0]     iseed;
  logic                  oready;
  logic                  ovalid;
  logic                  iready;
  logic [RESP_BITS-1:0]  oresponse;
  logic [UNST_W-1:0]     ounstable;

  modport slave  (input istart, iseed, iready,
                  output oready, ovalid, oresponse, ounstable);
  modport master (output istart, iseed, iready,
                  input oready, ovalid, oresponse, ounstable);
endinterface

// File: rtl/arbiter_puf_engine_lfsr.sv
// Challenge expander: Fibonacci LFSR, shift left with feedback into bit 0.
//   iload  : load iseed (an all-zero seed becomes 1, the LFSR lock-up state)
//   istep  : advance one step
//   ostate : current challenge
module puf_challenge_lfsr
  import puf_pkg::*;
#(
  parameter int STAGES = 8
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              iload,
  input  logic [STAGES-1:0] iseed,
  input  logic              istep,
  output logic [STAGES-1:0] ostate
);

  localparam logic [63:0]       TAPS_FULL = tap_mask(STAGES);
  localparam logic [STAGES-1:0] TAPS      = TAPS_FULL[STAGES-1:0];

  logic fb;
  assign fb = ^(ostate & TAPS);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      ostate <= '0;
    end else if (iload) begin
      ostate <= (iseed == '0) ? STAGES'(1) : iseed;
    end else if (istep) begin
      ostate <= {ostate[STAGES-2:0], fb};
    end
  end

endmodule

// File: rtl/arbiter_puf_engine.sv
// Arbiter PUF controller. Expands a seed into one challenge per response
// bit, fires the external delay line VOTES times per challenge, majority-
// votes the synchronised arbiter output and returns the response.
//   iclk, irst_n : clock, asynchronous active-low reset
//   bus          : request/response handshake (slave side)
//   ochallenge   : challenge to the delay line
//   opulse       : launch pulse to the delay line
//   iarb         : raw arbiter flop output, asynchronous to iclk
module arbiter_puf_engine
  import puf_pkg::*;
#(
  parameter int STAGES        = 8,
  parameter int RESP_BITS     = 16,
  parameter int VOTES         = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  iclk,
  input  logic                  irst_n,
  arbiter_puf_engine_if.slave   bus,
  output logic [STAGES-1:0]     ochallenge,
  output logic                  opulse,
  input  logic                  iarb
);

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("arbiter_puf_engine: STAGES must be 8, 16, 32 or 64");
  end
  if ((VOTES < 1) || ((VOTES % 2) == 0)) begin : g_bad_votes
    $error("arbiter_puf_engine: VOTES must be odd and at least 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("arbiter_puf_engine: SETTLE_CYCLES must be at least 1");
  end

  localparam int PH_W   = $clog2(SETTLE_CYCLES + 3);
  localparam int VOTE_W = $clog2(VOTES + 1);
  localparam int ONES_W = $clog2(VOTES + 1);
  localparam int BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int UNST_W = $clog2(RESP_BITS + 1);

  localparam logic [PH_W-1:0]   SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0]   FIRE_LAST   = PH_W'(SETTLE_CYCLES + 1);
  localparam logic [VOTE_W-1:0] VOTE_LAST   = VOTE_W'(VOTES - 1);
  localparam logic [ONES_W-1:0] ONES_ALL    = ONES_W'(VOTES);
  localparam logic [ONES_W-1:0] ONES_HALF   = ONES_W'(VOTES / 2);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(RESP_BITS - 1);

  state_t              state;
  logic [PH_W-1:0]     phase;
  logic [VOTE_W-1:0]   vote;
  logic [ONES_W-1:0]   ones;
  logic [BIT_W-1:0]    bit_idx;
  logic                arb_p0;
  logic                arb_p1;
  logic                lfsr_load;
  logic                lfsr_step;
  logic                last_relax;

  // Stage p0/p1: two-flop synchroniser for the asynchronous arbiter output
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      arb_p0 <= 1'b0;
      arb_p1 <= 1'b0;
    end else begin
      arb_p0 <= iarb;
      arb_p1 <= arb_p0;
    end
  end

  // Final RELAX cycle of the last vote for this bit
  assign last_relax = (state == RELAX) && (phase == SETTLE_LAST) && (vote == VOTE_LAST);
  assign lfsr_load  = (state == IDLE) && bus.istart;
  // No step after the last bit, so the challenge only moves on SETUP entry
  assign lfsr_step  = last_relax && (bit_idx != BIT_LAST);

  puf_challenge_lfsr #(.STAGES(STAGES)) u_lfsr (
    .iclk   (iclk),
    .irst_n (irst_n),
    .iload  (lfsr_load),
    .iseed  (bus.iseed),
    .istep  (lfsr_step),
    .ostate (ochallenge)
  );

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state         <= IDLE;
      phase         <= '0;
      vote          <= '0;
      ones          <= '0;
      bit_idx       <= '0;
      opulse        <= 1'b0;
      bus.oready    <= 1'b1;
      bus.ovalid    <= 1'b0;
      bus.oresponse <= '0;
      bus.ounstable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.istart) begin
            state         <= SETUP;
            phase         <= '0;
            vote          <= '0;
            ones          <= '0;
            bit_idx       <= '0;
            bus.oready    <= 1'b0;
            bus.oresponse <= '0;
            bus.ounstable <= '0;
          end
        end
        SETUP: begin
          if (phase == SETTLE_LAST) begin
            phase  <= '0;
            opulse <= 1'b1;
            state  <= FIRE;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        FIRE: begin
          // Two extra cycles let the arbiter result cross the synchroniser
          if (phase == FIRE_LAST) begin
            phase <= '0;
            state <= SAMPLE;
          end else begin
            phase <= phase + PH_W'(1);
          end
        end
        SAMPLE: begin
          ones   <= ones + ONES_W'(arb_p1);
          opulse <= 1'b0;
          state  <= RELAX;
        end
        RELAX: begin
          if (phase != SETTLE_LAST) begin
            phase <= phase + PH_W'(1);
          end else begin
            phase <= '0;
            if (vote != VOTE_LAST) begin
              vote  <= vote + VOTE_W'(1);
              state <= SETUP;
            end else begin
              bus.oresponse[bit_idx] <= (ones > ONES_HALF);
              if ((ones != '0) && (ones != ONES_ALL)) begin
                bus.ounstable <= bus.ounstable + UNST_W'(1);
              end
              vote <= '0;
              ones <= '0;
              if (bit_idx == BIT_LAST) begin
                state <= DONE;
              end else begin
                bit_idx <= bit_idx + BIT_W'(1);
                state   <= SETUP;
              end
            end
          end
        end
        DONE: begin
          // ovalid rises one cycle after entry, once the last bit has landed
          if (!bus.ovalid) begin
            bus.ovalid <= 1'b1;
          end else if (bus.iready) begin
            bus.ovalid <= 1'b0;
            bus.oready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          opulse     <= 1'b0;
          bus.oready <= 1'b1;
          bus.ovalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_puf_engine.sv
// Directed bench: a small configuration (8/2/1/1) and the default
// configuration (8/16/3/4) side by side on one clock.
module tb_arbiter_puf_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s_n, rst_d_n;
  logic [7:0] chal_s, chal_d;
  logic       pulse_s, pulse_d;
  logic       arb_s, arb_d;

  arbiter_puf_engine_if #(.STAGES(8), .RESP_BITS(2))  bus_s ();
  arbiter_puf_engine_if #(.STAGES(8), .RESP_BITS(16)) bus_d ();

  arbiter_puf_engine #(.STAGES(8), .RESP_BITS(2), .VOTES(1), .SETTLE_CYCLES(1)) dut_s (
    .iclk(clk), .irst_n(rst_s_n), .bus(bus_s),
    .ochallenge(chal_s), .opulse(pulse_s), .iarb(arb_s)
  );

  arbiter_puf_engine #(.STAGES(8), .RESP_BITS(16), .VOTES(3), .SETTLE_CYCLES(4)) dut_d (
    .iclk(clk), .irst_n(rst_d_n), .bus(bus_d),
    .ochallenge(chal_d), .opulse(pulse_d), .iarb(arb_d)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] lfsr8(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // One request on the small engine; records the challenge at each pulse rise.
  task automatic run_small(input logic [7:0] seed, input logic arb, output int lat,
                           output logic [7:0] c0, output logic [7:0] c1, output int np);
    logic prev;
    bus_s.iseed  = seed;
    arb_s        = arb;
    bus_s.istart = 1'b1;
    @(negedge clk);
    bus_s.istart = 1'b0;
    chk("small_busy_oready", bus_s.oready, 1'b0);
    lat = 0; np = 0; c0 = '0; c1 = '0; prev = 1'b0;
    while (!bus_s.ovalid && lat < 100) begin
      if (pulse_s && !prev) begin
        if (np == 0) c0 = chal_s;
        else         c1 = chal_s;
        np++;
      end
      prev = pulse_s;
      @(negedge clk);
      lat++;
    end
  endtask

  int         lat, np, hi_run, lo_run, bad_hi, bad_lo, bad_ch, bad_hold, bad;
  logic [7:0] c0, c1, exp_ch, held;
  logic [15:0] resp_hold;

  initial begin
    rst_s_n = 1'b0; rst_d_n = 1'b0;
    arb_s = 1'b0; arb_d = 1'b0;
    bus_s.istart = 1'b0; bus_s.iseed = '0; bus_s.iready = 1'b0;
    bus_d.istart = 1'b0; bus_d.iseed = '0; bus_d.iready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_s_oready",    bus_s.oready,    1'b1);
    chk("rst_s_ovalid",    bus_s.ovalid,    1'b0);
    chk("rst_s_oresponse", bus_s.oresponse, 2'b00);
    chk("rst_s_ounstable", bus_s.ounstable, 0);
    chk("rst_s_chal",      chal_s,          8'h00);
    chk("rst_s_pulse",     pulse_s,         1'b0);
    chk("rst_d_oready",    bus_d.oready,    1'b1);
    chk("rst_d_ovalid",    bus_d.ovalid,    1'b0);
    chk("rst_d_oresponse", bus_d.oresponse, 16'h0000);
    chk("rst_d_ounstable", bus_d.ounstable, 0);
    chk("rst_d_chal",      chal_d,          8'h00);
    chk("rst_d_pulse",     pulse_d,         1'b0);
    rst_s_n = 1'b1; rst_d_n = 1'b1;
    @(negedge clk);

    // Small config, seed 80, arbiter tied high
    run_small(8'h80, 1'b1, lat, c0, c1, np);
    chk("s80_latency",   lat,             13);
    chk("s80_chal0",     c0,              8'h80);
    chk("s80_chal1",     c1,              8'h01);
    chk("s80_npulse",    np,              2);
    chk("s80_resp",      bus_s.oresponse, 2'b11);
    chk("s80_unstable",  bus_s.ounstable, 0);
    chk("s80_no_ready",  bus_s.oready,    1'b0);
    bus_s.iready = 1'b1;
    @(negedge clk);
    bus_s.iready = 1'b0;
    chk("s80_hs_oready", bus_s.oready,    1'b1);
    chk("s80_hs_ovalid", bus_s.ovalid,    1'b0);

    // Small config, zero seed, arbiter tied low
    run_small(8'h00, 1'b0, lat, c0, c1, np);
    chk("s00_latency",  lat,             13);
    chk("s00_chal0",    c0,              8'h01);
    chk("s00_chal1",    c1,              8'h02);
    chk("s00_resp",     bus_s.oresponse, 2'b00);
    chk("s00_unstable", bus_s.ounstable, 0);
    bus_s.iready = 1'b1;
    @(negedge clk);
    bus_s.iready = 1'b0;
    chk("s00_hs_oready", bus_s.oready, 1'b1);

    // Defaults: votes 1,0,1 per bit, pulse shape and challenge sequence
    exp_ch = 8'hA5; held = '0;
    lat = 0; np = 0; hi_run = 0; lo_run = 0;
    bad_hi = 0; bad_lo = 0; bad_ch = 0; bad_hold = 0;
    bus_d.iseed  = 8'hA5;
    bus_d.istart = 1'b1;
    @(negedge clk);
    bus_d.istart = 1'b0;
    while (!bus_d.ovalid && lat < 1000) begin
      if (pulse_d) begin
        if (hi_run == 0) begin
          if (lo_run != ((np == 0) ? 4 : 8)) bad_lo++;
          held = chal_d;
          if (chal_d !== exp_ch) bad_ch++;
          arb_d = ((np % 3) == 1) ? 1'b0 : 1'b1;
          np++;
          if ((np % 3) == 0) exp_ch = lfsr8(exp_ch);
        end else if (chal_d !== held) begin
          bad_hold++;
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run != 0 && hi_run != 7) bad_hi++;
        hi_run = 0;
        lo_run++;
      end
      @(negedge clk);
      lat++;
    end
    chk("def_latency",    lat,             721);
    chk("def_npulse",     np,              48);
    chk("def_low_runs",   bad_lo,          0);
    chk("def_high_runs",  bad_hi,          0);
    chk("def_challenges", bad_ch,          0);
    chk("def_chal_hold",  bad_hold,        0);
    chk("def_resp",       bus_d.oresponse, 16'hFFFF);
    chk("def_unstable",   bus_d.ounstable, 16);
    chk("def_oready",     bus_d.oready,    1'b0);

    // Backpressure in DONE with stray istart pulses
    resp_hold = bus_d.oresponse;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      bus_d.istart = ((i % 7) == 0);
      @(negedge clk);
      if (!bus_d.ovalid || bus_d.oready || bus_d.oresponse !== resp_hold ||
          bus_d.ounstable !== 5'd16 || pulse_d) bad++;
    end
    bus_d.istart = 1'b0;
    chk("bp_hold", bad, 0);
    bus_d.iready = 1'b1;
    @(negedge clk);
    bus_d.iready = 1'b0;
    chk("bp_hs_oready", bus_d.oready, 1'b1);
    chk("bp_hs_ovalid", bus_d.ovalid, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_idle_oready", bus_d.oready, 1'b1);
    chk("bp_idle_pulse",  pulse_d,      1'b0);

    // Asynchronous reset in the middle of FIRE
    bus_d.iseed  = 8'h3C;
    bus_d.istart = 1'b1;
    @(negedge clk);
    bus_d.istart = 1'b0;
    lat = 0;
    while (!pulse_d && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_reached_fire", pulse_d, 1'b1);
    #2 rst_d_n = 1'b0;
    #1;
    chk("mid_rst_pulse",     pulse_d,         1'b0);
    chk("mid_rst_oready",    bus_d.oready,    1'b1);
    chk("mid_rst_ovalid",    bus_d.ovalid,    1'b0);
    chk("mid_rst_oresponse", bus_d.oresponse, 16'h0000);
    chk("mid_rst_ounstable", bus_d.ounstable, 0);
    chk("mid_rst_chal",      chal_d,          8'h00);
    @(negedge clk);
    rst_d_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (bus_d.ovalid || pulse_d || !bus_d.oready) bad++;
    end
    chk("mid_rst_quiet", bad, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arbiter_puf_engine.md
# arbiter_puf_engine

Parametrised controller for the next-generation arbiter PUF. It accepts a seed challenge and expands it through an LFSR into one challenge per response bit. For each challenge it drives the external delay-line/arbiter pair a configurable number of times and majority-votes the arbiter output. The assembled multi-bit response is returned over a valid/ready handshake. It sits between the system bus logic and the delay-line + arbiter-flop pair, replacing the single-bit, free-running pulse/challenge drive.

## Interface
- STAGES, 8, challenge width = delay-line stage count; legal values 8, 16, 32, 64
- RESP_BITS, 16, response bits produced per request
- VOTES, 3, evaluations per response bit; odd, ≥1 (elaboration error otherwise)
- SETTLE_CYCLES, 4, cycles per setup/fire/relax phase; ≥1

- iclk  in  1  clock
- irst_n  in  1  asynchronous active-low reset
- istart  in  1  request valid
- iseed  in  STAGES  seed challenge, sampled on acceptance
- oready  out  1  engine idle, can accept a request
- ovalid  out  1  response valid
- iready  in  1  consumer accepts response
- oresponse  out  RESP_BITS  majority-voted response; bit k from challenge k
- ounstable  out  $clog2(RESP_BITS+1)  count of bits whose votes were not unanimous
- ochallenge  out  STAGES  challenge to delay line
- opulse  out  1  launch pulse to delay line
- iarb  in  1  raw arbiter flop output (asynchronous to iclk)

## Operation
- Reset values: oready=1, ovalid=0, oresponse=0, ounstable=0, ochallenge=0, opulse=0, state IDLE.
- States:
  - IDLE: oready=1. On istart=1, accept: load the LFSR with iseed (0 is replaced by 1), clear the bit, vote and ones counters, oresponse and ounstable, then go to SETUP.
  - SETUP: ochallenge=LFSR, opulse=0, for SETTLE_CYCLES cycles.
  - FIRE: opulse=1 for SETTLE_CYCLES+2 cycles (covers the 2-flop synchroniser on iarb).
  - SAMPLE: 1 cycle; opulse stays 1; add the synchronised iarb to the ones counter.
  - RELAX: opulse=0 for SETTLE_CYCLES cycles. Then:
    - If votes remain, go to SETUP.
    - Otherwise write oresponse[bit] = (ones > VOTES/2).
    - Increment ounstable if ones ∉ {0, VOTES}.
    - Step the LFSR, clear vote/ones, advance bit. Go to SETUP, or to DONE after bit RESP_BITS-1.
  - DONE: ovalid=1; oresponse and ounstable are stable. On iready=1, go to IDLE next cycle.
- The LFSR is Fibonacci: next = {s[STAGES-2:0], fb}, fb = XOR of the tap bits.
  - Taps (bit indices): 8: 7,5,4,3; 16: 15,14,12,3; 32: 31,21,1,0; 64: 63,62,60,59.
  - Bit 0 uses the seed (after zero substitution) unmodified.
- istart is ignored outside IDLE. iready is ignored outside DONE.
- No abort input. Asserting irst_n=0 mid-operation forces reset values immediately, including opulse=0.

## Timing
- Each vote takes 3·SETTLE_CYCLES+3 cycles.
- Latency from the acceptance edge to ovalid=1 is RESP_BITS·VOTES·(3·SETTLE_CYCLES+3)+1 cycles. Defaults give 721.
- ochallenge changes only on the SETUP entry edge, never while opulse=1.
- oready and ovalid are never high together. oready returns to 1 one cycle after the iready handshake.
- The synchroniser resets to 0.

## Structure
- Shared package `puf_pkg`:
  - state enum (IDLE, SETUP, FIRE, SAMPLE, RELAX, DONE)
  - function returning the tap mask for STAGES
  - legal-STAGES check constant
- Sub-module `puf_challenge_lfsr`: parameter STAGES; ports iclk, irst_n, iload, iseed, istep, ostate; includes zero-seed substitution.
- The engine holds the FSM, phase/vote/bit counters and the 2-flop iarb synchroniser.
- The delay line and arbiter flop stay outside. The top level connects opulse/ochallenge to them and the arbiter Q to iarb.

## Test plan
- Reset mid-FIRE: assert irst_n=0 → opulse=0, oready=1, ovalid=0, oresponse=0 immediately. No response is produced after release.
- STAGES=8, RESP_BITS=2, VOTES=1, SETTLE_CYCLES=1; iseed=8'h80; iarb tied 1 → ochallenge=8'h80 then 8'h01; ovalid 13 cycles after acceptance; oresponse=2'b11, ounstable=0.
- Same config, iseed=8'h00 → the first challenge driven is 8'h01, the second 8'h02.
- Defaults, iarb pattern 1,0,1 per bit (votes differ) → every oresponse bit = 1, ounstable=16, ovalid at cycle 721.
- Backpressure: iready held 0 for 50 cycles in DONE → ovalid and oresponse hold, istart pulses are ignored, oready=0. On iready=1, oready=1 in the next cycle.
- Opulse shape, defaults: per vote, 4 low, then 7 high (FIRE 6 + SAMPLE 1), then 4 low. 48 pulses total. ochallenge is constant during each high period.
